cube_loader: RTL and testbench

- Upstream feeder for the cube solver core (`main`).
- Accepts a cube-state frame as a stream of 30 nibbles over a valid/ready handshake and assembles the 120-bit state word `d`.
- Sanity-checks the word: reserved field must be zero, and the edge-permutation field must be a permutation of 0..11.
- On pass, holds `d` stable and raises `run` to the core until released. On fail, flags an error code and `run` stays low.

---
 rtl/cube_pkg.sv | 28 ++
 rtl/cube_loader_perm_checker.sv | 59 +++++
 rtl/cube_loader.sv | 162 ++++++++++++++++
 tb/tb_cube_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the cube loader: FSM states, word field bounds and error codes.
package cube_pkg;

    localparam int NIB   = 30;
    localparam int EDGES = 12;

    localparam int RSV_HI = 119;
    localparam int RSV_LO = 108;
    localparam int EP_LO  = 60;
    localparam int EP_W   = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        RUN     = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_PERM = 2'd2;
    localparam logic [1:0] ERR_RSV  = 2'd3;

    function automatic logic slot_in_range(input logic [3:0] v, input int n);
        return (v < 4'(n));
    endfunction

endpackage

// File: rtl/cube_loader_perm_checker.sv
// Sequential permutation checker: one slot per cycle, flags out-of-range or repeated values.
module perm_checker
    import cube_pkg::*;
#(
    parameter int N = EDGES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       valid_i,
    input  logic [3:0] value_i,
    input  logic       last_i,
    output logic       bad_o,
    output logic       done_o
);

    logic [N-1:0] seen_q;
    logic         bad_q;
    logic         done_q;
    logic         ranged_s;
    logic         hit_s;

    // Range test and duplicate lookup for the slot presented this cycle
    always_comb begin
        ranged_s = slot_in_range(value_i, N);
        hit_s    = 1'b0;
        if (ranged_s) begin
            hit_s = seen_q[value_i];
        end else begin
            hit_s = 1'b0;
        end
    end

    // Seen mask, sticky bad flag and one-cycle done pulse after the last slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= '0;
            bad_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            seen_q <= '0;
            bad_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (valid_i) begin
            done_q <= last_i;
            if (!ranged_s || hit_s) begin
                bad_q <= 1'b1;
            end else begin
                seen_q[value_i] <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bad_o  = bad_q;
    assign done_o = done_q;

endmodule

// File: rtl/cube_loader.sv
// Assembles a 120-bit cube state from 30 nibbles, validates it and hands it to the solver core.
module cube_loader
    import cube_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_data,
    input  logic         in_last,
    input  logic         release_i,
    output logic [119:0] d,
    output logic         run,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);

    state_t       state_q;
    logic [4:0]   count_q;
    logic [3:0]   idx_q;
    logic [119:0] d_q;
    logic         in_ready_q;
    logic         run_q;
    logic         busy_q;
    logic         err_q;
    logic [1:0]   err_code_q;

    logic         accept_s;
    logic         frame_ok_s;
    logic         chk_valid_s;
    logic         chk_last_s;
    logic [3:0]   slot_idx_s;
    logic [3:0]   slot_s;
    logic         chk_bad_s;
    logic         chk_done_s;
    logic         rsv_nz_s;

    // Handshake qualification and slot selection for the checker
    always_comb begin
        accept_s    = in_valid & in_ready_q;
        frame_ok_s  = accept_s & in_last & (count_q == 5'(NIB - 1));
        chk_valid_s = (state_q == CHECK) && (idx_q < 4'(EDGES));
        chk_last_s  = (idx_q == 4'(EDGES - 1));
        rsv_nz_s    = (d_q[RSV_HI:RSV_LO] != 12'd0);
        if (chk_valid_s) begin
            slot_idx_s = idx_q;
        end else begin
            slot_idx_s = 4'd0;
        end
        slot_s = d_q[EP_LO + EP_W * slot_idx_s +: EP_W];
    end

    perm_checker #(.N(EDGES)) u_perm (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (frame_ok_s),
        .valid_i (chk_valid_s),
        .value_i (slot_s),
        .last_i  (chk_last_s),
        .bad_o   (chk_bad_s),
        .done_o  (chk_done_s)
    );

    // Loader FSM with all outputs registered; reserved error outranks permutation error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            count_q    <= 5'd0;
            idx_q      <= 4'd0;
            d_q        <= 120'd0;
            in_ready_q <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            case (state_q)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        d_q     <= {d_q[115:0], in_data};
                        count_q <= count_q + 5'd1;
                        if (frame_ok_s) begin
                            state_q    <= CHECK;
                            idx_q      <= 4'd0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else if (in_last || (count_q == 5'(NIB - 1))) begin
                            state_q    <= ERROR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_LEN;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end else begin
                        state_q <= COLLECT;
                    end
                end
                CHECK: begin
                    if (chk_valid_s) begin
                        idx_q <= idx_q + 4'd1;
                    end else if (chk_done_s) begin
                        busy_q <= 1'b0;
                        if (rsv_nz_s) begin
                            state_q    <= ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RSV;
                        end else if (chk_bad_s) begin
                            state_q    <= ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_PERM;
                        end else begin
                            state_q <= RUN;
                            run_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= CHECK;
                    end
                end
                RUN: begin
                    if (release_i) begin
                        state_q    <= COLLECT;
                        run_q      <= 1'b0;
                        count_q    <= 5'd0;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                ERROR: begin
                    if (release_i) begin
                        state_q    <= COLLECT;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        count_q    <= 5'd0;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q <= ERROR;
                    end
                end
                default: begin
                    state_q    <= COLLECT;
                    in_ready_q <= 1'b0;
                    run_q      <= 1'b0;
                    busy_q     <= 1'b0;
                    err_q      <= 1'b0;
                    err_code_q <= ERR_NONE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign d        = d_q;
    assign run      = run_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_cube_loader.sv
// Self-checking bench for cube_loader: directed frames plus randomized frames against a reference model.
module tb_cube_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_data;
    logic         in_last;
    logic         release_i;
    logic [119:0] d;
    logic         run;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    int total = 0;
    int bad   = 0;

    logic [119:0] base_w;

    always #5 clk = ~clk;

    cube_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .release_i (release_i),
        .d         (d),
        .run       (run),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    // Reference verdict for a complete 30-nibble frame
    function automatic logic [1:0] model_code(input logic [119:0] w);
        int cnt [16];
        bit dup;
        logic [3:0] v;
        dup = 1'b0;
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        if (w[119:108] != 12'd0) return 2'd3;
        for (int k = 0; k < 12; k++) begin
            v = w[60 + 4*k +: 4];
            if (v > 4'd11 || cnt[v] != 0) dup = 1'b1;
            cnt[v] = cnt[v] + 1;
        end
        return dup ? 2'd2 : 2'd0;
    endfunction

    task automatic send_nibbles(input logic [119:0] w, input int n, input bit mark_last, input int gap_pct);
        int t;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[119 - 4*i -: 4];
            in_last  = mark_last && (i == n - 1);
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL ready_timeout: nibble %0d got in_ready=%0b required 1", i, in_ready);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_release();
        release_i = 1'b1;
        @(posedge clk); #1;
        release_i = 1'b0;
    endtask

    // Called #1 after the edge that accepted the final nibble
    task automatic check_result(input string name, input logic [119:0] w, input logic [1:0] exp);
        int cyc;
        if (exp == 2'd1) begin
            total++;
            if (err !== 1'b1 || err_code !== 2'd1 || in_ready !== 1'b0 || run !== 1'b0) begin
                bad++;
                $display("FAIL %s_len: got err=%0b code=%0d rdy=%0b run=%0b required err=1 code=1 rdy=0 run=0",
                         name, err, err_code, in_ready, run);
            end
        end else begin
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy: got busy=%0b rdy=%0b required busy=1 rdy=0", name, busy, in_ready);
            end
            cyc = 0;
            while (!(run === 1'b1 || err === 1'b1) && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            total++;
            if (cyc !== 13) begin
                bad++;
                $display("FAIL %s_latency: got %0d cycles required 13", name, cyc);
            end
            total++;
            if (exp == 2'd0) begin
                if (run !== 1'b1 || err !== 1'b0 || d !== w || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_run: got run=%0b err=%0b d=%h required run=1 err=0 d=%h",
                             name, run, err, d, w);
                end
            end else begin
                if (run !== 1'b0 || err !== 1'b1 || err_code !== exp) begin
                    bad++;
                    $display("FAIL %s_err: got run=%0b err=%0b code=%0d required run=0 err=1 code=%0d",
                             name, run, err, err_code, exp);
                end
            end
        end
        pulse_release();
        total++;
        if (run !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release: got run=%0b err=%0b code=%0d rdy=%0b required 0 0 0 1",
                     name, run, err, err_code, in_ready);
        end
        if (exp == 2'd0) begin
            total++;
            if (d !== w) begin
                bad++;
                $display("FAIL %s_d_hold: got %h required %h", name, d, w);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0; release_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || run !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0 || d !== 120'd0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%0b run=%0b err=%0b busy=%0b code=%0d d=%h required all zero",
                     in_ready, run, err, busy, err_code, d);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_valid_frame();
        send_nibbles(base_w, 30, 1'b1, 0);
        check_result("valid", base_w, model_code(base_w));
    endtask

    task automatic test_bad_frames();
        logic [119:0] w;
        w = base_w; w[60 + 4*3 +: 4] = 4'd5;
        send_nibbles(w, 30, 1'b1, 0);
        check_result("dup", w, 2'd2);
        w = base_w; w[60 +: 4] = 4'hF;
        send_nibbles(w, 30, 1'b1, 0);
        check_result("range", w, 2'd2);
        w = base_w; w[60 + 4*3 +: 4] = 4'd5; w[119:108] = 12'h001;
        send_nibbles(w, 30, 1'b1, 0);
        check_result("reserved", w, 2'd3);
    endtask

    task automatic test_length();
        send_nibbles(base_w, 10, 1'b1, 0);
        check_result("short", base_w, 2'd1);
        send_nibbles(base_w, 30, 1'b0, 0);
        check_result("long", base_w, 2'd1);
    endtask

    task automatic test_gaps();
        send_nibbles(base_w, 30, 1'b1, 25);
        check_result("gaps", base_w, 2'd0);
    endtask

    task automatic test_reset_mid_frame();
        send_nibbles(base_w, 17, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (d !== 120'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: got d=%h rdy=%0b required d=0 rdy=0", d, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_nibbles(base_w, 30, 1'b1, 0);
        check_result("midreset", base_w, 2'd0);
    endtask

    task automatic test_random();
        logic [119:0] w;
        logic [63:0]  r;
        logic [3:0]   perm [12];
        logic [3:0]   tmp;
        int j;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 12; i++) perm[i] = 4'(i);
            for (int i = 11; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            r = {$urandom(), $urandom()};
            w = 120'd0;
            w[59:0] = r[59:0];
            for (int k = 0; k < 12; k++) w[60 + 4*k +: 4] = perm[k];
            if ($urandom_range(2, 0) == 0) w[60 + 4*$urandom_range(11, 0) +: 4] = 4'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) w[119:108] = 12'($urandom_range(4095, 1));
            send_nibbles(w, 30, 1'b1, $urandom_range(30, 0));
            check_result("random", w, model_code(w));
        end
    endtask

    initial begin
        base_w = {12'h000, 48'hBA98_7654_2103, 60'h000_7654_0003_2103};
        test_reset();
        test_valid_frame();
        test_bad_frames();
        test_length();
        test_gaps();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
